// File: rtl/ntt_pkg.sv
// Shared constants for the NTT job scheduler: polynomial geometry and scheduler state encoding.
package ntt_pkg;

  localparam int unsigned COEF_W = 32;
  localparam int unsigned N_COEF = 256;
  localparam int unsigned POLY_W = N_COEF * COEF_W;

  localparam int unsigned ST_W = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARB       = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RECOVER   = 3'd4;

endpackage

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  int unsigned w_j;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = (32'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[IDW'(w_j)]) begin
        o_any = 1'b1;
        o_idx = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Shares one NTT core among NREQ requesters: round-robin grant, start/rd_done/done handshake,
// result capture and a watchdog that resets the core when a job stalls.
module ntt_job_scheduler
  import ntt_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned COOLDOWN = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*POLY_W-1:0] req_poly,
  output logic [NREQ-1:0]        gnt,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [POLY_W-1:0]      res_poly,
  output logic                   err,
  output logic [IDW-1:0]         err_id,
  output logic                   busy,
  output logic                   core_start,
  output logic [POLY_W-1:0]      core_inp,
  input  logic                   core_rd_done,
  input  logic                   core_done,
  input  logic [POLY_W-1:0]      core_out,
  output logic                   core_rst
);

  localparam int unsigned WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [CDW-1:0] CD_INIT = CDW'(COOLDOWN);

  logic [ST_W-1:0]   r_state,     w_state;
  logic [IDW-1:0]    r_rr_ptr,    w_rr_ptr;
  logic [IDW-1:0]    r_sel,       w_sel;
  logic [CDW-1:0]    r_cool,      w_cool;
  logic [WDW-1:0]    r_wdog,      w_wdog;
  logic              r_rec,       w_rec;
  logic              r_rd_q,      r_done_q;
  logic [NREQ-1:0]   r_gnt,       w_gnt;
  logic              r_res_valid, w_res_valid;
  logic [IDW-1:0]    r_res_id,    w_res_id;
  logic [POLY_W-1:0] r_res_poly,  w_res_poly;
  logic              r_err,       w_err;
  logic [IDW-1:0]    r_err_id,    w_err_id;
  logic              r_busy,      w_busy;
  logic              r_core_start, w_core_start;
  logic              r_core_rst,  w_core_rst;

  logic              w_rd_rise, w_done_rise, w_timeout, w_any;
  logic [IDW-1:0]    w_idx, w_ptr_adv;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_rd_rise   = core_rd_done & ~r_rd_q;
  assign w_done_rise = core_done & ~r_done_q;
  assign w_timeout   = (r_wdog == WD_LAST);
  assign w_ptr_adv   = (r_sel == IDW'(NREQ - 1)) ? '0 : r_sel + IDW'(1);

  // The mux follows sel even if the owner drops req mid-job.
  assign core_inp = req_poly[32'(r_sel) * POLY_W +: POLY_W];

  always_comb begin
    w_state      = r_state;
    w_rr_ptr     = r_rr_ptr;
    w_sel        = r_sel;
    w_cool       = r_cool;
    w_wdog       = r_wdog;
    w_rec        = r_rec;
    w_gnt        = '0;
    w_res_valid  = 1'b0;
    w_res_id     = r_res_id;
    w_res_poly   = r_res_poly;
    w_err        = 1'b0;
    w_err_id     = r_err_id;
    w_core_start = r_core_start;
    w_core_rst   = r_core_rst;
    case (r_state)
      ST_IDLE: begin
        if (r_cool != '0) w_cool = r_cool - CDW'(1);
        else if (|req)    w_state = ST_ARB;
      end
      ST_ARB: begin
        if (w_any) begin
          w_sel        = w_idx;
          w_wdog       = '0;
          w_core_start = 1'b1;
          w_state      = ST_START;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_START: begin
        if (!w_timeout) w_wdog = r_wdog + WDW'(1);
        if (w_rd_rise) begin
          w_core_start = 1'b0;
          w_gnt        = NREQ'(1) << r_sel;
          w_rr_ptr     = w_ptr_adv;
          w_state      = ST_WAIT_DONE;
        end else if (w_timeout) begin
          // Grant with the abort so the requester releases its request.
          w_core_start = 1'b0;
          w_gnt        = NREQ'(1) << r_sel;
          w_rr_ptr     = w_ptr_adv;
          w_err        = 1'b1;
          w_err_id     = r_sel;
          w_core_rst   = 1'b1;
          w_rec        = 1'b0;
          w_state      = ST_RECOVER;
        end
      end
      ST_WAIT_DONE: begin
        if (!w_timeout) w_wdog = r_wdog + WDW'(1);
        if (w_done_rise) begin
          w_res_poly  = core_out;
          w_res_id    = r_sel;
          w_res_valid = 1'b1;
          w_cool      = CD_INIT;
          w_state     = ST_IDLE;
        end else if (w_timeout) begin
          w_err      = 1'b1;
          w_err_id   = r_sel;
          w_core_rst = 1'b1;
          w_rec      = 1'b0;
          w_state    = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (r_rec) begin
          w_core_rst = 1'b0;
          w_cool     = CD_INIT;
          w_state    = ST_IDLE;
        end else begin
          w_rec = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_sel        <= '0;
      r_cool       <= '0;
      r_wdog       <= '0;
      r_rec        <= 1'b0;
      r_rd_q       <= 1'b0;
      r_done_q     <= 1'b0;
      r_gnt        <= '0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_poly   <= '0;
      r_err        <= 1'b0;
      r_err_id     <= '0;
      r_busy       <= 1'b0;
      r_core_start <= 1'b0;
      r_core_rst   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_rr_ptr     <= w_rr_ptr;
      r_sel        <= w_sel;
      r_cool       <= w_cool;
      r_wdog       <= w_wdog;
      r_rec        <= w_rec;
      r_rd_q       <= core_rd_done;
      r_done_q     <= core_done;
      r_gnt        <= w_gnt;
      r_res_valid  <= w_res_valid;
      r_res_id     <= w_res_id;
      r_res_poly   <= w_res_poly;
      r_err        <= w_err;
      r_err_id     <= w_err_id;
      r_busy       <= w_busy;
      r_core_start <= w_core_start;
      r_core_rst   <= w_core_rst;
    end
  end

  assign gnt        = r_gnt;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign res_poly   = r_res_poly;
  assign err        = r_err;
  assign err_id     = r_err_id;
  assign busy       = r_busy;
  assign core_start = r_core_start;
  assign core_rst   = r_core_rst;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler: requester drivers, a behavioural core model,
// and a transaction-level round-robin model that predicts grant order and outcomes.
module tb_ntt_job_scheduler;
  import ntt_pkg::*;

  localparam int unsigned NREQ = 4, IDW = 2, TIMEOUT = 256, COOLDOWN = 2, MAXJ = 3;
  localparam int MODE_OK = 0, MODE_START_TO = 1, MODE_DONE_TO = 2;

  logic clock = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*POLY_W-1:0] req_poly = '0;
  logic [NREQ-1:0] gnt;
  logic res_valid, err, busy, core_start, core_rst;
  logic [IDW-1:0] res_id, err_id;
  logic [POLY_W-1:0] res_poly, core_inp;
  logic core_rd_done = 1'b0, core_done = 1'b0;
  logic [POLY_W-1:0] core_out = '0;

  ntt_job_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN)) dut (
    .clock(clock), .reset(reset), .req(req), .req_poly(req_poly), .gnt(gnt),
    .res_valid(res_valid), .res_id(res_id), .res_poly(res_poly), .err(err), .err_id(err_id),
    .busy(busy), .core_start(core_start), .core_inp(core_inp), .core_rd_done(core_rd_done),
    .core_done(core_done), .core_out(core_out), .core_rst(core_rst)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { bit is_err; int id; bit err_gnt; logic [POLY_W-1:0] poly; } ev_t;
  typedef struct { int mode; int rd_lat; int done_lat; logic [POLY_W-1:0] inp; } job_t;
  ev_t  ev_q[$];
  int   gnt_q[$];
  job_t job_q[$];
  job_t forced_q[$];

  logic [POLY_W-1:0] polys [NREQ][MAXJ];
  int jobs_rem[NREQ], job_idx[NREQ], raise_cyc[NREQ];
  int rr_model = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_poly(input string name, input logic [POLY_W-1:0] a, input logic [POLY_W-1:0] b);
    int d;
    d = -1;
    for (int j = 0; j < N_COEF; j++)
      if (d < 0 && a[j*COEF_W +: COEF_W] != b[j*COEF_W +: COEF_W]) d = j;
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s: coef %0d got %08h expected %08h", name, d, a[d*COEF_W +: COEF_W], b[d*COEF_W +: COEF_W]);
    end
  endtask

  // Stand-in for the golden transform: per-coefficient affine map.
  function automatic logic [POLY_W-1:0] xform(input logic [POLY_W-1:0] x);
    logic [POLY_W-1:0] y;
    y = '0;
    for (int j = 0; j < N_COEF; j++)
      y[j*COEF_W +: COEF_W] = (x[j*COEF_W +: COEF_W] * 32'd17 + 32'(j)) ^ 32'h5a5a0000;
    return y;
  endfunction

  function automatic logic [POLY_W-1:0] rand_poly();
    logic [POLY_W-1:0] p;
    p = '0;
    for (int j = 0; j < N_COEF; j++) p[j*COEF_W +: COEF_W] = $urandom();
    return p;
  endfunction

  task automatic push_job(input int mode, input int rd, input int dn);
    job_t j;
    j.mode = mode; j.rd_lat = rd; j.done_lat = dn; j.inp = '0;
    forced_q.push_back(j);
  endtask

  // Serve waiting requesters in rotation from the pointer; each job yields one grant and one outcome.
  task automatic plan_phase(input int nj [NREQ]);
    int left[NREQ], idx[NREQ];
    int ptr, pick;
    bit any;
    job_t j;
    ev_t e;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = nj[i]; idx[i] = 0;
      for (int k = 0; k < nj[i]; k++) polys[i][k] = rand_poly();
    end
    ptr = rr_model;
    any = 1'b1;
    while (any) begin
      any = 1'b0; pick = 0;
      for (int k = 0; k < NREQ; k++)
        if (!any && left[(ptr + k) % NREQ] > 0) begin any = 1'b1; pick = (ptr + k) % NREQ; end
      if (any) begin
        if (forced_q.size() > 0) j = forced_q.pop_front();
        else begin
          pick = pick;
          j.mode = ($urandom_range(0, 9) < 8) ? MODE_OK : (($urandom_range(0, 1) == 0) ? MODE_START_TO : MODE_DONE_TO);
          j.rd_lat = $urandom_range(1, 5);
          j.done_lat = $urandom_range(j.rd_lat + 2, 120);
        end
        j.inp = polys[pick][idx[pick]];
        job_q.push_back(j);
        gnt_q.push_back(pick);
        e.is_err = (j.mode != MODE_OK);
        e.id = pick;
        e.err_gnt = (j.mode == MODE_START_TO);
        e.poly = xform(j.inp);
        ev_q.push_back(e);
        left[pick]--; idx[pick]++;
        ptr = (pick + 1) % NREQ;
      end
    end
    rr_model = ptr;
    for (int i = 0; i < NREQ; i++) begin job_idx[i] = 0; jobs_rem[i] = nj[i]; end
  endtask

  task automatic wait_phase();
    int k;
    k = 0;
    while (k < 6000 && !(ev_q.size() == 0 && gnt_q.size() == 0 && job_q.size() == 0 && !busy)) begin
      @(negedge clock); k++;
    end
    check(k < 6000, "phase_complete", 64'(k), 64'(6000));
    repeat (COOLDOWN + 3) @(negedge clock);
    check(busy == 1'b0, "busy_idle", 64'(busy), 64'(0));
  endtask

  // Requesters: hold until gnt, drop, re-raise the next cycle while jobs remain.
  always @(negedge clock) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i]) req[i] = 1'b0;
      else if (!req[i] && jobs_rem[i] > 0) begin
        req_poly[i*POLY_W +: POLY_W] = polys[i][job_idx[i]];
        req[i] = 1'b1;
        raise_cyc[i] = cyc;
        jobs_rem[i]--; job_idx[i]++;
      end
    end
  end

  // Core model: latencies and failure mode come from job_q in service order.
  bit c_active = 1'b0;
  int c_cnt = 0, last_done = -1;
  job_t c_job;
  logic [POLY_W-1:0] c_inp;
  always @(negedge clock) begin
    core_done = 1'b0;
    if (reset || core_rst) begin
      c_active = 1'b0; core_rd_done = 1'b0;
    end else if (c_active) begin
      c_cnt++;
      if (c_job.mode != MODE_START_TO && c_cnt >= c_job.rd_lat) core_rd_done = 1'b1;
      if (c_job.mode == MODE_OK && c_cnt == c_job.done_lat) begin
        core_out = xform(c_inp);
        core_done = 1'b1; core_rd_done = 1'b0; c_active = 1'b0;
        last_done = cyc;
      end
    end else if (core_start) begin
      if (job_q.size() == 0) check(1'b0, "unexpected_core_start", 64'(1), 64'(0));
      else begin
        c_job = job_q.pop_front();
        check_poly("core_inp", core_inp, c_job.inp);
        if (last_done >= 0) check(cyc - last_done >= COOLDOWN + 2, "start_gap", 64'(cyc - last_done), 64'(COOLDOWN + 2));
        c_inp = core_inp; c_active = 1'b1; c_cnt = 0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a grant, result or abort.
  ev_t m_ev;
  int m_g, rst_run = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (gnt_q.size() == 0) check(1'b0, "unexpected_gnt", 64'(gnt), 64'(0));
        else begin
          m_g = gnt_q.pop_front();
          check(gnt == (NREQ'(1) << m_g), "gnt_order", 64'(gnt), 64'(NREQ'(1) << m_g));
        end
      end
      if (err) begin
        if (ev_q.size() == 0) check(1'b0, "unexpected_err", 64'(err_id), 64'(0));
        else begin
          m_ev = ev_q.pop_front();
          check(m_ev.is_err, "err_expected_result", 64'(1), 64'(0));
          check(err_id == IDW'(m_ev.id), "err_id", 64'(err_id), 64'(m_ev.id));
          check(gnt == (m_ev.err_gnt ? (NREQ'(1) << m_ev.id) : NREQ'(0)), "err_gnt",
                64'(gnt), 64'(m_ev.err_gnt ? (NREQ'(1) << m_ev.id) : 0));
        end
      end
      if (res_valid) begin
        if (ev_q.size() == 0) check(1'b0, "unexpected_res_valid", 64'(res_id), 64'(0));
        else begin
          m_ev = ev_q.pop_front();
          check(!m_ev.is_err, "res_expected_err", 64'(1), 64'(0));
          check(res_id == IDW'(m_ev.id), "res_id", 64'(res_id), 64'(m_ev.id));
          check_poly("res_poly", res_poly, m_ev.poly);
        end
      end
      if (core_rst) rst_run++;
      else if (rst_run != 0) begin
        check(rst_run == 2, "core_rst_len", 64'(rst_run), 64'(2));
        rst_run = 0;
      end
    end
  end

  initial begin
    int k;
    int nj [NREQ];
    for (int i = 0; i < NREQ; i++) begin jobs_rem[i] = 0; job_idx[i] = 0; raise_cyc[i] = 0; end
    repeat (3) @(negedge clock);
    check(gnt == '0 && res_valid == 1'b0 && err == 1'b0, "rst_pulses", 64'({gnt, res_valid, err}), 64'(0));
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'(0));
    check(core_start == 1'b0 && core_rst == 1'b0, "rst_core_ctl", 64'({core_start, core_rst}), 64'(0));
    check(res_id == '0 && err_id == '0, "rst_ids", 64'({res_id, err_id}), 64'(0));
    check(res_poly == '0, "rst_res_poly", 64'(res_poly[63:0]), 64'(0));
    reset = 1'b0;

    // single job with latency check
    push_job(MODE_OK, 3, 200);
    plan_phase('{1, 0, 0, 0});
    k = 0;
    while (k < 50 && !core_start) begin @(negedge clock); k++; end
    check(core_start == 1'b1, "start_seen", 64'(core_start), 64'(1));
    check(cyc - raise_cyc[0] == 2, "start_latency", 64'(cyc - raise_cyc[0]), 64'(2));
    check(busy == 1'b1, "busy_in_job", 64'(busy), 64'(1));
    wait_phase();

    // round robin with re-raise
    for (int i = 0; i < 5; i++) push_job(MODE_OK, 2, 30 + i);
    plan_phase('{2, 1, 1, 1});
    wait_phase();

    // priority rotation: after 2, both 0 and 2 waiting
    push_job(MODE_OK, 3, 20);
    plan_phase('{0, 0, 1, 0});
    wait_phase();
    push_job(MODE_OK, 3, 20); push_job(MODE_OK, 3, 20);
    plan_phase('{1, 0, 1, 0});
    wait_phase();

    // start timeout
    push_job(MODE_START_TO, 0, 0);
    plan_phase('{0, 1, 0, 0});
    wait_phase();

    // done timeout then next requester
    push_job(MODE_DONE_TO, 3, 0); push_job(MODE_OK, 3, 40);
    plan_phase('{0, 0, 1, 1});
    wait_phase();

    // random phases
    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < NREQ; i++) nj[i] = $urandom_range(0, 2);
      plan_phase(nj);
      wait_phase();
    end

    // reset while waiting for done
    push_job(MODE_OK, 3, 200);
    plan_phase('{0, 1, 0, 0});
    k = 0;
    while (k < 100 && gnt_q.size() != 0) begin @(negedge clock); k++; end
    check(gnt_q.size() == 0, "rst_test_granted", 64'(gnt_q.size()), 64'(0));
    repeat (20) @(negedge clock);
    check(busy == 1'b1, "busy_wait_done", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    check(gnt == '0 && res_valid == 1'b0 && err == 1'b0, "midjob_rst_pulses", 64'({gnt, res_valid, err}), 64'(0));
    check(busy == 1'b0 && core_start == 1'b0 && core_rst == 1'b0, "midjob_rst_ctl", 64'({busy, core_start, core_rst}), 64'(0));
    check(res_id == '0 && err_id == '0 && res_poly == '0, "midjob_rst_data", 64'(res_poly[63:0]), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    ev_q.delete(); job_q.delete();
    rr_model = 0;
    repeat (30) @(negedge clock);
    push_job(MODE_OK, 2, 40);
    plan_phase('{0, 0, 0, 1});
    wait_phase();

    check(ev_q.size() == 0 && gnt_q.size() == 0 && job_q.size() == 0, "queues_drained",
          64'(ev_q.size() + gnt_q.size() + job_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
